// File: rtl/mesh_router_pkg.sv
// Shared port numbering and small helpers for the XY mesh router.
package mesh_router_pkg;

  localparam int NUM_PORTS = 5;
  localparam int PORT_W    = 3;

  localparam logic [PORT_W-1:0] PORT_LOCAL = 3'd0;
  localparam logic [PORT_W-1:0] PORT_NORTH = 3'd1;
  localparam logic [PORT_W-1:0] PORT_EAST  = 3'd2;
  localparam logic [PORT_W-1:0] PORT_SOUTH = 3'd3;
  localparam logic [PORT_W-1:0] PORT_WEST  = 3'd4;

  // Coordinate field width for a mesh dimension; a 1-wide mesh still gets one bit.
  function automatic int field_w(input int extent);
    return ($clog2(extent) > 1) ? $clog2(extent) : 1;
  endfunction

  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return (p == PORT_WEST) ? PORT_LOCAL : p + 3'd1;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input synchronous FIFO: writes into a full FIFO and reads from an empty one are ignored.
module router_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_router.sv
// 5-port single-flit XY router with per-input FIFOs and round-robin registered outputs.
// Optional MESH_ROUTER_STATS_EN adds per-output forwarded-flit counters (fwd_count).
module mesh_router
  import mesh_router_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int X_POS      = 0,
  parameter int Y_POS      = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]            out_valid,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic                            route_err
`ifdef MESH_ROUTER_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]         fwd_count
`endif
);

  localparam int X_W = field_w(COLS);
  localparam int Y_W = field_w(ROWS);

  // Handshake: a flit moves on any rising edge where valid && ready; valid never waits
  // on ready, and data is held stable while valid && !ready.

  logic [DATA_WIDTH-1:0]   head [NUM_PORTS];
  logic [PORT_W-1:0]       route [NUM_PORTS];
  logic [NUM_PORTS-1:0]    gnt [NUM_PORTS];
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused [NUM_PORTS];
  logic [NUM_PORTS-1:0]    full;
  logic [NUM_PORTS-1:0]    empty;
  logic [NUM_PORTS-1:0]    bad;
  logic [NUM_PORTS-1:0]    pop;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    logic [X_W-1:0]    dest_x;
    logic [Y_W-1:0]    dest_y;
    logic              bad_l;
    logic [PORT_W-1:0] route_l;

    router_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_valid[p]),
      .wr_data (in_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en   (pop[p]),
      .rd_data (head[p]),
      .full    (full[p]),
      .empty   (empty[p]),
      .count   (fifo_count_unused[p])
    );

    assign in_ready[p] = !full[p];
    assign dest_x      = head[p][DATA_WIDTH-1 -: X_W];
    assign dest_y      = head[p][DATA_WIDTH-1-X_W -: Y_W];

    // X first, then Y; destinations outside the mesh are sunk at the local node.
    always_comb begin
      bad_l   = (int'(dest_x) >= COLS) || (int'(dest_y) >= ROWS);
      route_l = PORT_LOCAL;
      if (bad_l)                       route_l = PORT_LOCAL;
      else if (int'(dest_x) > X_POS)   route_l = PORT_EAST;
      else if (int'(dest_x) < X_POS)   route_l = PORT_WEST;
      else if (int'(dest_y) > Y_POS)   route_l = PORT_SOUTH;
      else if (int'(dest_y) < Y_POS)   route_l = PORT_NORTH;
    end

    assign bad[p]   = bad_l;
    assign route[p] = route_l;
  end

  always_comb begin
    pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      pop = pop | gnt[o];
    end
  end

  assign route_err = !rst && (|(pop & bad));

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [NUM_PORTS-1:0]  req_l;
    logic [NUM_PORTS-1:0]  gnt_l;
    logic [PORT_W-1:0]     rr_ptr;
    logic [PORT_W-1:0]     win;
    logic [3:0]            cand;
    logic                  found;
    logic                  loadable;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_comb begin
      req_l = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        req_l[p] = !empty[p] && (route[p] == PORT_W'(o));
      end
    end

    assign loadable = !valid_q || out_ready[o];

    // Search starts at rr_ptr and wraps once around all five inputs.
    always_comb begin
      gnt_l = '0;
      win   = rr_ptr;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = {1'b0, rr_ptr} + 4'(k);
        if (cand >= 4'(NUM_PORTS)) cand = cand - 4'(NUM_PORTS);
        if (!found && loadable && req_l[cand[PORT_W-1:0]]) begin
          found = 1'b1;
          win   = cand[PORT_W-1:0];
        end
      end
      if (found) gnt_l[win] = 1'b1;
    end

    assign gnt[o] = gnt_l;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        rr_ptr  <= PORT_LOCAL;
      end else if (loadable) begin
        if (found) begin
          valid_q <= 1'b1;
          data_q  <= head[win];
          rr_ptr  <= next_port(win);
        end else if (out_ready[o]) begin
          valid_q <= 1'b0;
        end
      end
    end

    assign out_valid[o]                          = valid_q;
    assign out_data[o*DATA_WIDTH +: DATA_WIDTH] = data_q;

`ifdef MESH_ROUTER_STATS_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (valid_q && out_ready[o]) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end

    assign fwd_count[o*32 +: 32] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_mesh_router.sv
// Scoreboard bench for mesh_router at (1,1) of a 4-row x 5-column mesh (X_W=3, Y_W=2).
// Flit layout used here: {dest_x[2:0], dest_y[1:0], src_port[2:0], seq[23:0]}.
module tb_mesh_router;

  localparam int DW = 32;
  localparam int NP = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_valid;
  logic [NP-1:0]     in_ready;
  logic [NP*DW-1:0]  out_data;
  logic [NP-1:0]     out_valid;
  logic [NP-1:0]     out_ready;
  logic              route_err;
`ifdef MESH_ROUTER_STATS_EN
  logic [NP*32-1:0]  fwd_count;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mesh_router #(
    .ROWS       (4),
    .COLS       (5),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (4),
    .X_POS      (1),
    .Y_POS      (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .route_err (route_err)
`ifdef MESH_ROUTER_STATS_EN
    ,
    .fwd_count (fwd_count)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q [NP*NP][$];
  int            exp_fwd [NP];
  int            exp_err = 0;
  int            err_pulses = 0;
  int            n_vec = 0;
  int            n_err = 0;

  logic [DW-1:0] drv_flit [NP];
  logic [23:0]   seq [NP];

  logic          rot_on = 1'b0;
  logic          rot_have_last = 1'b0;
  int            rot_last = 0;
  int            rot_cnt = 0;
  logic          post_on = 1'b0;
  logic [2:0]    post_src [$];

  logic [DW-1:0] mon_d;
  int            mon_src;
  int            mon_key;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_flit(input logic [2:0] x, input logic [1:0] y,
                                             input logic [2:0] src, input logic [23:0] s);
    return {x, y, src, s};
  endfunction

  // Reference XY routing for this router at (1,1) of a 5-wide, 4-tall mesh.
  function automatic int ref_port(input logic [2:0] dx, input logic [1:0] dy);
    if (dx > 3'd4) return 0;
    if (dx > 3'd1) return 2;
    if (dx < 3'd1) return 4;
    if (dy > 2'd1) return 3;
    if (dy < 2'd1) return 1;
    return 0;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < NP*NP; k++) s += exp_q[k].size();
    return s;
  endfunction

  task automatic push_exp(input int p, input logic [DW-1:0] f);
    int o;
    o = ref_port(f[31:29], f[28:27]);
    exp_q[o*NP + p].push_back(f);
    exp_fwd[o]++;
    if (f[31:29] > 3'd4) exp_err++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [NP-1:0] mask, output logic [NP-1:0] acc);
    for (int p = 0; p < NP; p++) in_data[p*DW +: DW] = drv_flit[p];
    in_valid = mask;
    @(negedge clk);
    acc = in_valid & in_ready;
    for (int p = 0; p < NP; p++) if (acc[p]) push_exp(p, drv_flit[p]);
    @(posedge clk);
    #1;
    in_valid = '0;
  endtask

  task automatic next_flit(input int p, input logic [2:0] x, input logic [1:0] y);
    seq[p]++;
    drv_flit[p] = mk_flit(x, y, 3'(p), seq[p]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pending() != 0 && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check_eq("drain_pending", 64'(pending()), 64'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef MESH_ROUTER_STATS_EN
    for (int o = 0; o < NP; o++)
      check_eq($sformatf("%s_fwd%0d", tag, o), 64'(fwd_count[o*32 +: 32]), 64'(exp_fwd[o]));
`else
    if (tag.len() == 0) $display("stats disabled");
`endif
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (route_err) err_pulses++;
      for (int o = 0; o < NP; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          mon_d   = out_data[o*DW +: DW];
          mon_src = int'(mon_d[26:24]);
          if (mon_src >= NP) mon_src = 0;
          mon_key = o*NP + mon_src;
          check_eq($sformatf("out%0d_expected", o), 64'(exp_q[mon_key].size() != 0), 64'd1);
          if (exp_q[mon_key].size() != 0)
            check_eq($sformatf("out%0d_data", o), 64'(mon_d), 64'(exp_q[mon_key].pop_front()));
          if (o == 0 && rot_on) begin
            if (rot_have_last)
              check_eq("rr_order", 64'(mon_d[26:24]), 64'((rot_last == 3) ? 1 : rot_last + 1));
            rot_last      = int'(mon_d[26:24]);
            rot_have_last = 1'b1;
            rot_cnt++;
          end
          if (o == 0 && post_on) post_src.push_back(mon_d[26:24]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [NP-1:0] acc;
  logic [DW-1:0] hold;
  int            cnt;
  int            guard;
  int            err_before;

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '1;
    for (int p = 0; p < NP; p++) begin
      seq[p]      = '0;
      drv_flit[p] = '0;
      exp_fwd[p]  = 0;
    end
    repeat (2) tick();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(|out_data), 64'd0);
    check_eq("rst_route_err", 64'(route_err), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'h1f);
    rst = 1'b0;

    // Local-to-local minimum latency.
    drv_flit[0] = mk_flit(3'd1, 2'd1, 3'd0, 24'h0000AB);
    step(5'b00001, acc);
    check_eq("lat_accept", 64'(acc[0]), 64'd1);
    check_eq("lat_n1_valid", 64'(out_valid[0]), 64'd0);
    tick();
    check_eq("lat_n2_valid", 64'(out_valid[0]), 64'd1);
    check_eq("lat_n2_data", 64'(out_data[31:0]), 64'(mk_flit(3'd1, 2'd1, 3'd0, 24'h0000AB)));
    drain();

    // West->east and north->south in parallel.
    next_flit(4, 3'd3, 2'd0);
    next_flit(1, 3'd1, 2'd3);
    step(5'b10010, acc);
    check_eq("par_accept", 64'(acc), 64'h12);
    tick();
    check_eq("par_same_cycle", 64'({out_valid[3], out_valid[2]}), 64'd3);
    drain();

    // N, E, S all stream into LOCAL: grants must rotate with one flit per cycle.
    for (int p = 1; p <= 3; p++) next_flit(p, 3'd1, 2'd1);
    rot_on        = 1'b1;
    rot_have_last = 1'b0;
    rot_cnt       = 0;
    repeat (15) begin
      step(5'b01110, acc);
      for (int p = 1; p <= 3; p++) if (acc[p]) next_flit(p, 3'd1, 2'd1);
    end
    rot_on = 1'b0;
    check_eq("rr_throughput", 64'(rot_cnt), 64'd13);
    drain();

    // EAST stalled: FIFO plus output register absorb exactly five flits.
    out_ready = 5'b11011;
    cnt = 0;
    next_flit(0, 3'd3, 2'd1);
    repeat (8) begin
      step(5'b00001, acc);
      if (acc[0]) begin
        cnt++;
        next_flit(0, 3'd3, 2'd1);
      end
    end
    check_eq("bp_accepts", 64'(cnt), 64'd5);
    check_eq("bp_in_ready", 64'(in_ready[0]), 64'd0);
    check_eq("bp_out_valid", 64'(out_valid[2]), 64'd1);
    hold = out_data[2*DW +: DW];
    repeat (2) tick();
    check_eq("bp_hold_data", 64'(out_data[2*DW +: DW]), 64'(hold));
    out_ready = '1;
    drain();

    // Out-of-range destination goes LOCAL with a single route_err pulse.
    err_before = err_pulses;
    next_flit(0, 3'd5, 2'd1);
    step(5'b00001, acc);
    repeat (3) tick();
    check_eq("err_pulse_count", 64'(err_pulses - err_before), 64'd1);
    drain();

    // Ten EAST deliveries, then compare forwarded counters.
    cnt   = 0;
    guard = 0;
    next_flit(0, 3'd3, 2'd1);
    while (cnt < 10 && guard < 40) begin
      step(5'b00001, acc);
      guard++;
      if (acc[0]) begin
        cnt++;
        next_flit(0, 3'd3, 2'd1);
      end
    end
    check_eq("east10_accepts", 64'(cnt), 64'd10);
    drain();
    check_stats("pre_rst");

    // Reset in the middle of buffered traffic drops everything.
    out_ready = '0;
    next_flit(0, 3'd3, 2'd1);
    next_flit(1, 3'd1, 2'd1);
    repeat (4) begin
      step(5'b00011, acc);
      if (acc[0]) next_flit(0, 3'd3, 2'd1);
      if (acc[1]) next_flit(1, 3'd1, 2'd1);
    end
    rst = 1'b1;
    tick();
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_out_data", 64'(|out_data), 64'd0);
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'h1f);
`ifdef MESH_ROUTER_STATS_EN
    check_eq("mid_rst_fwd", 64'(|fwd_count), 64'd0);
`endif
    rst = 1'b0;
    for (int k = 0; k < NP*NP; k++) exp_q[k].delete();
    for (int o = 0; o < NP; o++) exp_fwd[o] = 0;
    out_ready = '1;
    repeat (4) tick();
    check_eq("post_rst_quiet", 64'(out_valid), 64'd0);

    // Arbiter pointers restart at port 0: N, E, S order.
    post_on = 1'b1;
    for (int p = 1; p <= 3; p++) next_flit(p, 3'd1, 2'd1);
    step(5'b01110, acc);
    drain();
    post_on = 1'b0;
    check_eq("post_rr_count", 64'(post_src.size()), 64'd3);
    if (post_src.size() == 3) begin
      check_eq("post_rr_first", 64'(post_src[0]), 64'd1);
      check_eq("post_rr_second", 64'(post_src[1]), 64'd2);
      check_eq("post_rr_third", 64'(post_src[2]), 64'd3);
    end

    check_eq("route_err_total", 64'(err_pulses), 64'(exp_err));
    check_stats("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
